// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
// Main control FSM for a multi-cycle MIPS datapath. It steps each instruction
// through fetch, decode, execute, memory and write-back, and drives the
// datapath mux selects, write enables and the 2-bit ALUop for the ALU control
// decoder. Memory states wait on mem_ready, so slow memory stretches them.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset, forces state to IF
//   Op          instruction[31:26] from IR (only used in ID and MADR)
//   mem_ready   memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUop[1:0], PCSource[1:0]
//               datapath controls, combinational from state (+ mem_ready)
//   state       current state encoding (debug)
//   instr_done  one-cycle pulse on an instruction's final cycle
//   illegal_op  one-cycle pulse in ID on an unsupported opcode
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_AEX  = 4'd10,
    S_AWB  = 4'd11
  } state_t;

  state_t state_reg, state_next;

  // Next-state logic. Unused codes 12-15 fall into the default and recover to IF.
  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF:   state_next = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (Op)
          OP_LW, OP_SW: state_next = S_MADR;
          OP_R:         state_next = S_REX;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JMP;
          OP_ADDI:      state_next = S_AEX;
          default:      state_next = S_IF;  // unsupported: NOP, PC already advanced
        endcase
      end
      S_MADR: state_next = (Op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:  state_next = mem_ready ? S_MWB : S_MRD;
      S_MWB:  state_next = S_IF;
      S_MWR:  state_next = mem_ready ? S_IF : S_MWR;
      S_REX:  state_next = S_RWB;
      S_RWB:  state_next = S_IF;
      S_BEQ:  state_next = S_IF;
      S_JMP:  state_next = S_IF;
      S_AEX:  state_next = S_AWB;
      S_AWB:  state_next = S_IF;
      default: state_next = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

  // Control outputs. Everything defaults to 0; each state raises only its own.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_reg)
      S_IF: begin
        // PC+4 is computed every fetch cycle but only committed with the IR
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_ID: begin
        // Speculative branch target into ALUOut
        ALUSrcB = 2'b11;
        case (Op)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          default:                                   illegal_op = 1'b1;
        endcase
      end
      S_MADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MWR: begin
        // Request is held through wait cycles; memory commits on mem_ready
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_AEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_AWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl
// Drives multi_cycle_ctrl with a directed opening (reset mid-load, then one of
// each opcode) followed by randomized opcodes, mem_ready and occasional resets.
// A reference model expands each instruction into its list of states and
// predicts every control output cycle by cycle.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  ctl_t obs_ctl;
  assign obs_ctl = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
                     PCSource, instr_done, illegal_op};

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  // Reference model: the current instruction as a queue of state codes.
  int         exp_q[$];
  logic [5:0] cur_op;
  logic [5:0] dir_ops[$];

  function automatic bit op_ok(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  function automatic bit waits_mem(input int s);
    return s == 0 || s == 3 || s == 5;
  endfunction

  task automatic build(input logic [5:0] op);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    if (op == OP_LW)        begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
    else if (op == OP_SW)   begin exp_q.push_back(2); exp_q.push_back(5); end
    else if (op == OP_R)    begin exp_q.push_back(6); exp_q.push_back(7); end
    else if (op == OP_BEQ)  exp_q.push_back(8);
    else if (op == OP_J)    exp_q.push_back(9);
    else if (op == OP_ADDI) begin exp_q.push_back(10); exp_q.push_back(11); end
  endtask

  task automatic new_instr();
    if (dir_ops.size() > 0) begin
      cur_op = dir_ops.pop_front();
    end else begin
      case ($urandom_range(0, 6))
        0: cur_op = OP_R;
        1: cur_op = OP_LW;
        2: cur_op = OP_SW;
        3: cur_op = OP_BEQ;
        4: cur_op = OP_J;
        5: cur_op = OP_ADDI;
        default: cur_op = 6'($urandom_range(0, 63));
      endcase
    end
    build(cur_op);
  endtask

  function automatic ctl_t exp_ctl(input int s, input logic mr, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  begin c.alu_src_b = 2'b11; c.illegal_op = !op_ok(op); end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; c.instr_done = mr; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.instr_done = 1; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock: drive, check away from the edge, then advance the model.
  task automatic step(input logic mr, input logic rst);
    int s;
    mem_ready = mr;
    reset     = rst;
    @(negedge clk);
    s = exp_q[0];
    $display("cyc=%0d op=%b ready=%b reset=%b state=%0d exp_state=%0d ctl=%h",
             cycle, Op, mr, rst, state, s, obs_ctl);
    chk("state", 32'(state), 32'(s));
    chk($sformatf("ctl_s%0d", s), 32'(obs_ctl), 32'(exp_ctl(s, mr, cur_op)));
    @(posedge clk);
    if (rst) begin
      build(cur_op);  // abandoned instruction restarts from fetch
    end else if (!(waits_mem(s) && !mr)) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) new_instr();
    end
    #1;
    Op = cur_op;
    cycle++;
  endtask

  initial begin
    int sw_waits;
    logic mr;
    reset     = 1'b1;
    mem_ready = 1'b0;
    Op        = 6'd0;
    dir_ops.push_back(OP_LW);
    dir_ops.push_back(OP_SW);
    dir_ops.push_back(OP_R);
    dir_ops.push_back(OP_BEQ);
    dir_ops.push_back(OP_J);
    dir_ops.push_back(OP_ADDI);
    dir_ops.push_back(6'b111111);
    dir_ops.push_back(OP_LW);
    repeat (2) @(posedge clk);
    #1;
    new_instr();
    Op = cur_op;

    // Reset state, then a load interrupted by reset while waiting in MRD
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Directed: restarted lw, sw with 3 wait cycles in MWR, R, beq, j, addi,
    // illegal, lw; memory otherwise always ready
    sw_waits = 0;
    for (int i = 0; i < 40; i++) begin
      mr = 1'b1;
      if (exp_q[0] == 5 && sw_waits < 3) begin
        mr = 1'b0;
        sw_waits++;
      end
      step(mr, 1'b0);
    end

    // Randomized opcodes, memory latency and occasional resets
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
